preg_freelist: RTL

Circular free list of physical register IDs for the rename stage. It hands out up to ALLOC_W free pregs per cycle to renaming and takes back the superseded pregs of up to RETIRE_W retiring instructions per cycle from the ROB. It keeps a speculative head and an architectural head, so a flush restores the free list in one cycle. It replaces the fixed-width allocator with independently parametrised allocate and retire widths, prefix-packed grants and checkpoint-free recovery.

---
 rtl/common_pkg.sv | 5 +
 rtl/renaming_pkg.sv | 17 +
 rtl/preg_freelist_prefix_count.sv | 23 ++
 rtl/preg_freelist.sv | 99 +++++++++
 4 files changed

// File: rtl/common_pkg.sv
// Machine-wide width constants shared across the pipeline.
package common;
    localparam int MACHINE_WIDTH = 2;
    localparam int ISSUE_WIDTH   = 2;
endpackage

// File: rtl/renaming_pkg.sv
// Rename-stage types and sizing shared by the free list and its users.
package renaming_pkg;
    localparam int DEF_PREG_NUM = 64;
    localparam int DEF_AREG_NUM = 32;
    localparam int PREG_ADDR_W  = $clog2(DEF_PREG_NUM);
    localparam int DEPTH        = DEF_PREG_NUM - DEF_AREG_NUM;
    localparam int PTR_W        = $clog2(DEPTH) + 1;

    typedef logic [PREG_ADDR_W-1:0] preg_addr_t;
    // MSB of a free-list pointer is the wrap bit.
    typedef logic [PTR_W-1:0]       fl_ptr_t;

    // Width needed to hold a population count of n bits.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction
endpackage

// File: rtl/preg_freelist_prefix_count.sv
// Exclusive prefix popcount: prefix slot i holds popcount(bits[i-1:0]).
module prefix_count
    import renaming_pkg::*;
#(
    parameter int N  = 2,
    parameter int CW = cnt_w(N)
) (
    input  logic [N-1:0]    bits,
    output logic [N*CW-1:0] prefix,
    output logic [CW-1:0]   total
);
    logic [CW-1:0] acc;

    always_comb begin
        acc    = '0;
        prefix = '0;
        for (int i = 0; i < N; i++) begin
            prefix[i*CW +: CW] = acc;
            acc = acc + CW'(bits[i]);
        end
        total = acc;
    end
endmodule

// File: rtl/preg_freelist.sv
// Circular physical-register free list with speculative/architectural heads
// so a flush restores the list in a single cycle.
module preg_freelist
    import renaming_pkg::*;
#(
    parameter int PREG_NUM   = DEF_PREG_NUM,
    parameter int AREG_NUM   = DEF_AREG_NUM,
    parameter int ALLOC_W    = common::MACHINE_WIDTH,
    parameter int RETIRE_W   = common::ISSUE_WIDTH,
    localparam int PREG_W    = $clog2(PREG_NUM)
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic [ALLOC_W-1:0]         alloc_req,
    output logic                       alloc_ready,
    output logic [ALLOC_W*PREG_W-1:0]  alloc_preg,
    input  logic [RETIRE_W-1:0]        retire_valid,
    input  logic [RETIRE_W*PREG_W-1:0] retire_old_preg,
    input  logic                       flush,
    output logic [PREG_W:0]            free_count
);
    localparam int FL_DEPTH = PREG_NUM - AREG_NUM;
    localparam int IDX_W    = $clog2(FL_DEPTH);
    localparam int FL_PTR_W = IDX_W + 1;
    localparam int ACW      = cnt_w(ALLOC_W);
    localparam int RCW      = cnt_w(RETIRE_W);
    localparam logic [PREG_W:0] DEPTH_C   = (PREG_W+1)'(FL_DEPTH);
    localparam logic [PREG_W:0] ALLOC_W_C = (PREG_W+1)'(ALLOC_W);

    logic [PREG_W-1:0]      entries [FL_DEPTH];
    logic [FL_PTR_W-1:0]    spec_head;
    logic [FL_PTR_W-1:0]    arch_head;
    logic [FL_PTR_W-1:0]    tail;
    logic [FL_PTR_W-1:0]    occupancy;
    logic [ALLOC_W*ACW-1:0] alloc_pre;
    logic [ACW-1:0]         alloc_tot;
    logic [RETIRE_W*RCW-1:0] retire_pre;
    logic [RCW-1:0]         retire_tot;
    logic [IDX_W-1:0]       rd_idx [ALLOC_W];
    logic [IDX_W-1:0]       wr_idx [RETIRE_W];
    logic                   fire;

    prefix_count #(.N(ALLOC_W)) u_alloc_cnt (
        .bits   (alloc_req),
        .prefix (alloc_pre),
        .total  (alloc_tot)
    );

    prefix_count #(.N(RETIRE_W)) u_retire_cnt (
        .bits   (retire_valid),
        .prefix (retire_pre),
        .total  (retire_tot)
    );

    assign occupancy   = tail - spec_head;
    assign free_count  = (PREG_W+1)'(occupancy);
    assign alloc_ready = (free_count >= ALLOC_W_C);
    assign fire        = alloc_ready & (|alloc_req) & ~flush;

    // Grants read pre-edge storage, so same-cycle retire writes are never seen.
    always_comb begin
        alloc_preg = '0;
        for (int i = 0; i < ALLOC_W; i++) begin
            rd_idx[i] = IDX_W'(spec_head + FL_PTR_W'(alloc_pre[i*ACW +: ACW]));
            alloc_preg[i*PREG_W +: PREG_W] = entries[rd_idx[i]];
        end
        for (int j = 0; j < RETIRE_W; j++) begin
            wr_idx[j] = IDX_W'(tail + FL_PTR_W'(retire_pre[j*RCW +: RCW]));
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < FL_DEPTH; k++) begin
                entries[k] <= PREG_W'(AREG_NUM + k);
            end
            spec_head <= '0;
            arch_head <= '0;
            tail      <= FL_PTR_W'(FL_DEPTH);
        end else begin
            for (int j = 0; j < RETIRE_W; j++) begin
                if (retire_valid[j]) begin
                    entries[wr_idx[j]] <= retire_old_preg[j*PREG_W +: PREG_W];
                end
            end
            tail      <= tail + FL_PTR_W'(retire_tot);
            arch_head <= arch_head + FL_PTR_W'(retire_tot);
            // Restore targets the post-retire architectural head.
            if (flush) begin
                spec_head <= arch_head + FL_PTR_W'(retire_tot);
            end else if (fire) begin
                spec_head <= spec_head + FL_PTR_W'(alloc_tot);
            end
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!resetn)
        free_count <= DEPTH_C);
endmodule
